// File: rtl/seq_divider64.sv
// rtl/seq_divider64.sv - restoring divider, one quotient bit per clock, start/busy/done handshake
// Define SIGNED_DIV_EN to honour is_signed (truncating two's-complement divide with MIN/-1 overflow flag).
module seq_divider64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;
    logic             unused_diff_bit;

    // The partial remainder can reach 2*D-1 after the shift, so the compare needs one extra bit.
    assign rem_sh          = {r_q, a_q[WIDTH-1]};
    assign diff            = {1'b0, rem_sh} - {2'b00, d_q};
    assign fits            = ~diff[WIDTH+1];
    assign r_d             = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign a_d             = {a_q[WIDTH-2:0], fits};
    assign unused_diff_bit = diff[WIDTH];

`ifdef SIGNED_DIV_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic neg_quo_q;
    logic neg_rem_q;
    logic ovf_pend_q;
    logic ovf_q;
    logic a_neg;
    logic b_neg;
    logic is_ovf;

    assign a_neg   = is_signed & dividend[WIDTH-1];
    assign b_neg   = is_signed & divisor[WIDTH-1];
    assign mag_a   = a_neg ? (~dividend + 1'b1) : dividend;
    assign mag_b   = b_neg ? (~divisor + 1'b1) : divisor;
    assign is_ovf  = is_signed && (dividend == MIN_VAL) && (divisor == {WIDTH{1'b1}});
    assign quo_fin = neg_quo_q ? (~a_d + 1'b1) : a_d;
    assign rem_fin = neg_rem_q ? (~r_d + 1'b1) : r_d;
    assign overflow = ovf_q;

    // Magnitude of MIN is MIN itself, so MIN/-1 naturally yields quotient MIN and remainder 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            ovf_pend_q <= is_ovf;
            ovf_q      <= 1'b0;
        end else if (state_q == S_RUN && cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
            ovf_q      <= ovf_pend_q;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign mag_a    = dividend;
    assign mag_b    = divisor;
    assign quo_fin  = a_d;
    assign rem_fin  = r_d;
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            a_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        r_q    <= '0;
                        a_q    <= mag_a;
                        d_q    <= mag_b;
                        cnt_q  <= CNT_INIT;
                        if (divisor == '0) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                        end else begin
                            state_q <= S_RUN;
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= r_d;
                    a_q   <= a_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        quotient_q  <= quo_fin;
                        remainder_q <= rem_fin;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider64.sv
// tb/tb_seq_divider64.sv - randomized self-checking bench for seq_divider64 against an arithmetic model
module tb_seq_divider64;

    localparam int W = 64;
    localparam logic [W-1:0] MIN64 = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         is_signed = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int failures = 0;

    seq_divider64 #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .is_signed(is_signed),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd64();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        return v >> $urandom_range(0, 63);
    endfunction

    function automatic void uref(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic void sref(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic ov);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        ov = 1'b0;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (a == MIN64 && b == '1) begin
            q = MIN64;
            r = '0;
            ov = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
        wait_idle();
        dividend = a;
        divisor = b;
        is_signed = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero, overflow, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b ovf=%b q=%h r=%h required all 0",
                     busy, done, div_by_zero, overflow, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        int lat;
        run_op(64'd100, 64'd7, 1'b0, lat);
        checks++;
        if (lat != 65 || quotient !== 64'd14 || remainder !== 64'd2 || {div_by_zero, overflow} !== 2'b00) begin
            failures++;
            $display("FAIL div_100_7: got lat=%0d q=%0d r=%0d dbz=%b ovf=%b required 65 14 2 0 0",
                     lat, quotient, remainder, div_by_zero, overflow);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (quotient !== 64'd14 || remainder !== 64'd2 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL hold_after_done: got q=%0d r=%0d busy=%b done=%b required 14 2 0 0",
                     quotient, remainder, busy, done);
        end
        run_op('1, 64'd1, 1'b0, lat);
        checks++;
        if (lat != 65 || quotient !== '1 || remainder !== '0) begin
            failures++;
            $display("FAIL div_max_1: got lat=%0d q=%h r=%h required 65 ffffffffffffffff 0",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        run_op(64'd42, 64'd0, 1'b0, lat);
        checks++;
        if (lat != 1 || quotient !== '1 || remainder !== 64'd42 || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL div_by_zero: got lat=%0d q=%h r=%0d dbz=%b ovf=%b required 1 all-ones 42 1 0",
                     lat, quotient, remainder, div_by_zero, overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_pulse_hold: got done=%b dbz=%b required 0 1", done, div_by_zero);
        end
        run_op(64'd50, 64'd5, 1'b0, lat);
        checks++;
        if (div_by_zero !== 1'b0 || quotient !== 64'd10 || remainder !== 64'd0) begin
            failures++;
            $display("FAIL dbz_clear: got dbz=%b q=%0d r=%0d required 0 10 0", div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_start_during_run();
        int n_done;
        int lat;
        n_done = 0;
        lat = 0;
        wait_idle();
        dividend = 64'd1000;
        divisor = 64'd9;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            @(negedge clk);
            if (e == 10) begin
                start = 1'b1;
                dividend = 64'd77;
                divisor = 64'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) lat = e + 1;
            end
        end
        start = 1'b0;
        checks++;
        if (n_done != 1 || lat != 65 || quotient !== 64'd111 || remainder !== 64'd1) begin
            failures++;
            $display("FAIL start_in_run: got dones=%0d lat=%0d q=%0d r=%0d required 1 65 111 1",
                     n_done, lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int n_done;
        n_done = 0;
        wait_idle();
        dividend = 64'd12345;
        divisor = 64'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, overflow, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_mid_op: got busy=%b done=%b q=%h r=%h required all 0",
                     busy, done, quotient, remainder);
        end
        for (int i = 0; i < 70; i++) begin
            if (i == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses required 0", n_done);
        end
        run_op(64'd9, 64'd3, 1'b0, lat);
        checks++;
        if (lat != 65 || quotient !== 64'd3 || remainder !== 64'd0) begin
            failures++;
            $display("FAIL after_reset_9_3: got lat=%0d q=%0d r=%0d required 65 3 0", lat, quotient, remainder);
        end
    endtask

    task automatic test_random_unsigned();
        int lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        for (int i = 0; i < 20; i++) begin
            a = rnd64();
            b = rnd64();
            if (b == 0) b = 64'd3;
            uref(a, b, eq, er);
            run_op(a, b, 1'b0, lat);
            checks++;
            if (lat != 65 || quotient !== eq || remainder !== er || {div_by_zero, overflow} !== 2'b00) begin
                failures++;
                $display("FAIL rand_unsigned %h/%h: got lat=%0d q=%h r=%h required 65 q=%h r=%h",
                         a, b, lat, quotient, remainder, eq, er);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [3];
        logic [W-1:0] ob [3];
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int k;
        int prev;
        k = 0;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            oa[i] = rnd64();
            ob[i] = rnd64() | 64'd1;
        end
        wait_idle();
        dividend = oa[0];
        divisor = ob[0];
        is_signed = 1'b0;
        start = 1'b1;
        for (int e = 0; e < 300 && k < 3; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                uref(oa[k], ob[k], eq, er);
                checks++;
                if (quotient !== eq || remainder !== er || (k == 0 && e != 64) || (k > 0 && e - prev != 66)) begin
                    failures++;
                    $display("FAIL back_to_back op%0d: got edge=%0d q=%h r=%h required spacing 66 q=%h r=%h",
                             k, e, quotient, remainder, eq, er);
                end
                prev = e;
                k++;
                if (k < 3) begin
                    dividend = oa[k];
                    divisor = ob[k];
                end
            end
        end
        start = 1'b0;
        checks++;
        if (k != 3) begin
            failures++;
            $display("FAIL back_to_back_count: got %0d results required 3", k);
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        int lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic eo;
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, lat);
        checks++;
        if (lat != 65 || quotient !== 64'hFFFF_FFFF_FFFF_FFFD || remainder !== '1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL signed_m7_2: got lat=%0d q=%h r=%h ovf=%b required 65 -3 -1 0",
                     lat, quotient, remainder, overflow);
        end
        run_op(MIN64, '1, 1'b1, lat);
        checks++;
        if (lat != 65 || quotient !== MIN64 || remainder !== '0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL signed_min_m1: got lat=%0d q=%h r=%h ovf=%b required 65 8000000000000000 0 1",
                     lat, quotient, remainder, overflow);
        end
        for (int i = 0; i < 12; i++) begin
            a = rnd64();
            b = rnd64();
            if (b == 0) b = 64'd5;
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            sref(a, b, eq, er, eo);
            run_op(a, b, 1'b1, lat);
            checks++;
            if (lat != 65 || quotient !== eq || remainder !== er || overflow !== eo) begin
                failures++;
                $display("FAIL rand_signed %h/%h: got q=%h r=%h ovf=%b required q=%h r=%h ovf=%b",
                         a, b, quotient, remainder, overflow, eq, er, eo);
            end
        end
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, lat);
        checks++;
        if (quotient !== 64'h7FFF_FFFF_FFFF_FFFC || remainder !== 64'd1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL signed_build_unsigned_op: got q=%h r=%h ovf=%b required 7ffffffffffffffc 1 0",
                     quotient, remainder, overflow);
        end
    endtask
`else
    task automatic test_signed();
        int lat;
        run_op(MIN64, '1, 1'b1, lat);
        checks++;
        if (quotient !== 64'd0 || remainder !== MIN64 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL is_signed_ignored_min: got q=%h r=%h ovf=%b required 0 8000000000000000 0",
                     quotient, remainder, overflow);
        end
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, lat);
        checks++;
        if (lat != 65 || quotient !== 64'h7FFF_FFFF_FFFF_FFFC || remainder !== 64'd1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL is_signed_ignored: got lat=%0d q=%h r=%h ovf=%b required 65 7ffffffffffffffc 1 0",
                     lat, quotient, remainder, overflow);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_start_during_run();
        test_reset_mid_op();
        test_random_unsigned();
        test_back_to_back();
        test_signed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
